// File: rtl/adder_tree_acc_ctrl_pkg.sv
// Shared types for the NN datapath sequencing controllers.
package nn_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } acc_state_e;

endpackage

// File: rtl/adder_tree.sv
// Combinational binary reduction of NUM zero-extended lanes into one OUT_WIDTH sum.
module adder_tree #(
    parameter int IN_WIDTH  = 8,
    parameter int NUM       = 4,
    parameter int OUT_WIDTH = 32
) (
    input  logic [NUM*IN_WIDTH-1:0] in_data,
    output logic [OUT_WIDTH-1:0]    tree_sum
);

    localparam int LEVELS = $clog2(NUM);
    localparam int NP     = 1 << LEVELS;

    // Level 0 holds the lanes padded to a power of two; each level halves the node count.
    for (genvar gi = 0; gi <= LEVELS; gi++) begin : g_lvl
        localparam int N = NP >> gi;
        logic [OUT_WIDTH-1:0] sum [N];

        for (genvar gj = 0; gj < N; gj++) begin : g_node
            if (gi == 0) begin : g_leaf
                if (gj < NUM) begin : g_lane
                    assign sum[gj] = OUT_WIDTH'(in_data[gj*IN_WIDTH +: IN_WIDTH]);
                end else begin : g_pad
                    assign sum[gj] = '0;
                end
            end else begin : g_add
                assign sum[gj] = g_lvl[gi-1].sum[2*gj] + g_lvl[gi-1].sum[2*gj+1];
            end
        end
    end

    assign tree_sum = g_lvl[LEVELS].sum[0];

endmodule

// File: rtl/adder_tree_acc_ctrl.sv
// Accepts cfg_len beats, reduces each through adder_tree, accumulates, and presents one result.
module adder_tree_acc_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int IN_WIDTH  = 8,
    parameter int NUM       = 4,
    parameter int OUT_WIDTH = 32,
    parameter int MAX_LEN   = 256,
    localparam int LEN_W    = $clog2(MAX_LEN + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [LEN_W-1:0]        cfg_len,
    output logic                    busy,
    output logic                    err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM*IN_WIDTH-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [OUT_WIDTH-1:0]    out_data
);

    acc_state_e           state_q;
    logic [LEN_W-1:0]     cnt_q;
    logic [OUT_WIDTH-1:0] acc_q;
    logic [OUT_WIDTH-1:0] acc_d;
    logic [OUT_WIDTH-1:0] tree_sum;
    logic                 busy_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic                 err_q;
    logic                 len_ok;
    logic                 beat;

    adder_tree #(
        .IN_WIDTH (IN_WIDTH),
        .NUM      (NUM),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_tree (
        .in_data (in_data),
        .tree_sum(tree_sum)
    );

    assign len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    assign beat   = in_valid && in_ready_q;
    assign acc_d  = acc_q + tree_sum;

    // Handshake outputs are kept as flops so they never depend on the peer's valid/ready.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len_ok) begin
                            cnt_q      <= cfg_len;
                            acc_q      <= '0;
                            state_q    <= ACC;
                            busy_q     <= 1'b1;
                            in_ready_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (beat) begin
                        acc_q <= acc_d;
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_q     <= OUT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    busy_q      <= 1'b0;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign err       = err_q;
    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;

endmodule

// File: tb/tb_adder_tree_acc_ctrl.sv
// Scenario-per-task bench with an expected-result queue for adder_tree_acc_ctrl.
module tb_adder_tree_acc_ctrl;

    localparam int LEN_W = 9;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  cfg_len;
    logic        busy, err, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data;
    logic [31:0] out_data;

    // Narrow-accumulator instance for the wrap scenario
    logic        w_start, w_in_valid, w_out_ready;
    logic [8:0]  w_cfg_len;
    logic [31:0] w_in_data;
    logic        w_busy, w_err, w_in_ready, w_out_valid;
    logic [9:0]  w_out_data;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q [$];
    logic [31:0] expv;

    always #5 clk = ~clk;

    adder_tree_acc_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len), .busy(busy), .err(err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    adder_tree_acc_ctrl #(.OUT_WIDTH(10)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(w_start), .cfg_len(w_cfg_len), .busy(w_busy), .err(w_err),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
        return {d[7:0], c[7:0], b[7:0], a[7:0]};
    endfunction

    function automatic logic [31:0] lane_sum(input logic [31:0] d);
        return 32'(d[7:0]) + 32'(d[15:8]) + 32'(d[23:16]) + 32'(d[31:24]);
    endfunction

    task automatic do_start(input int len);
        start   = 1'b1;
        cfg_len = len[8:0];
        step();
        start   = 1'b0;
    endtask

    task automatic feed(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({busy, err, in_ready, out_valid} !== 4'b0000 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset: busy=%b err=%b in_ready=%b out_valid=%b out_data=%0d required all 0",
                     busy, err, in_ready, out_valid, out_data);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_min_job();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = pack4(1, 2, 3, 4);
        exp_q.push_back(32'd10);
        do_start(1);
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL min_accept: busy=%b in_ready=%b required 1 1", busy, in_ready);
        end
        step();
        in_valid = 1'b0;
        expv = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== expv || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL min_result: out_valid=%b out_data=%0d in_ready=%b required 1 %0d 0",
                     out_valid, out_data, in_ready, expv);
        end
        $display("min_job result=%0d expected=%0d", out_data, expv);
        step();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL min_idle: out_valid=%b busy=%b required 0 0", out_valid, busy);
        end
    endtask

    task automatic test_bubbles();
        logic [31:0] beats [3];
        beats[0] = pack4(1, 1, 1, 1);
        beats[1] = pack4(2, 2, 2, 2);
        beats[2] = pack4(3, 3, 3, 3);
        out_ready = 1'b1;
        exp_q.push_back(32'd24);
        do_start(3);
        for (int i = 0; i < 3; i++) begin
            feed(beats[i]);
            if (i < 2) begin
                step();
                step();
                checks++;
                if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL bubble_hold%0d: in_ready=%b out_valid=%b required 1 0",
                             i, in_ready, out_valid);
                end
            end
        end
        expv = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== expv) begin
            failures++;
            $display("FAIL bubble_result: out_valid=%b out_data=%0d required 1 %0d", out_valid, out_data, expv);
        end
        $display("bubbles result=%0d expected=%0d", out_data, expv);
        step();
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        exp_q.push_back(32'd24);
        do_start(3);
        for (int i = 0; i < 3; i++) feed(pack4(2, 2, 2, 2));
        expv = exp_q.pop_front();
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== expv || err !== 1'b0) begin
                failures++;
                $display("FAIL stall_cycle%0d: out_valid=%b out_data=%0d err=%b required 1 %0d 0",
                         c, out_valid, out_data, err, expv);
            end
            start   = (c == 1);
            cfg_len = 9'd1;
            step();
            start   = 1'b0;
        end
        $display("stall result=%0d expected=%0d", out_data, expv);
        out_ready = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0) begin
            failures++;
            $display("FAIL stall_release: busy=%b out_valid=%b err=%b required 0 0 0", busy, out_valid, err);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        w_out_ready = 1'b1;
        w_in_valid  = 1'b1;
        w_in_data   = pack4(255, 255, 255, 255);
        exp_q.push_back(32'd2040 % 32'd1024);
        w_start   = 1'b1;
        w_cfg_len = 9'd2;
        step();
        w_start = 1'b0;
        cyc = 0;
        while (w_out_valid !== 1'b1 && cyc < 10) begin
            step();
            cyc++;
        end
        w_in_valid = 1'b0;
        expv = exp_q.pop_front();
        checks++;
        if (w_out_valid !== 1'b1 || 32'(w_out_data) !== expv) begin
            failures++;
            $display("FAIL wrap: out_valid=%b out_data=%0d required 1 %0d", w_out_valid, w_out_data, expv);
        end
        $display("wrap result=%0d expected=%0d", w_out_data, expv);
        step();
    endtask

    task automatic test_err();
        int lens [2];
        lens[0] = 0;
        lens[1] = 257;
        for (int i = 0; i < 2; i++) begin
            do_start(lens[i]);
            checks++;
            if (err !== 1'b1 || busy !== 1'b0) begin
                failures++;
                $display("FAIL err_pulse len=%0d: err=%b busy=%b required 1 0", lens[i], err, busy);
            end
            step();
            checks++;
            if (err !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL err_single len=%0d: err=%b busy=%b required 0 0", lens[i], err, busy);
            end
            $display("err_start len=%0d", lens[i]);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        do_start(4);
        feed(pack4(9, 9, 9, 9));
        feed(pack4(7, 7, 7, 7));
        rst_n = 1'b0;
        step();
        checks++;
        if ({busy, err, in_ready, out_valid} !== 4'b0000 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b err=%b in_ready=%b out_valid=%b out_data=%0d required all 0",
                     busy, err, in_ready, out_valid, out_data);
        end
        rst_n = 1'b1;
        step();
        exp_q.push_back(32'd20);
        do_start(1);
        feed(pack4(5, 5, 5, 5));
        expv = exp_q.pop_front();
        checks++;
        if (out_valid !== 1'b1 || out_data !== expv) begin
            failures++;
            $display("FAIL reset_fresh: out_valid=%b out_data=%0d required 1 %0d", out_valid, out_data, expv);
        end
        $display("reset_fresh result=%0d expected=%0d", out_data, expv);
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [31:0] sum;
        int cyc;
        out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            int len;
            len = 2 + j;
            sum = '0;
            do_start(len);
            for (int b = 0; b < len; b++) begin
                d = $urandom;
                sum += lane_sum(d);
                feed(d);
            end
            exp_q.push_back(sum);
            cyc = 0;
            while (out_valid !== 1'b1 && cyc < 10) begin
                step();
                cyc++;
            end
            expv = exp_q.pop_front();
            checks++;
            if (out_valid !== 1'b1 || out_data !== expv) begin
                failures++;
                $display("FAIL b2b_job%0d: out_valid=%b out_data=%0d required 1 %0d", j, out_valid, out_data, expv);
            end
            $display("b2b job=%0d len=%0d result=%0d expected=%0d", j, len, out_data, expv);
            step();
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cfg_len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        w_start = 1'b0; w_cfg_len = '0; w_in_valid = 1'b0; w_in_data = '0; w_out_ready = 1'b0;
        test_reset();
        test_min_job();
        test_bubbles();
        test_stall();
        test_wrap();
        test_err();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adder_tree_acc_ctrl.md
# adder_tree_acc_ctrl

Sequencing controller around the combinational `adder_tree` reduction. It accepts a configured number of NUM-lane input beats over a valid/ready stream and reduces each beat through the tree. It accumulates the per-beat sums into one OUT_WIDTH result and presents that result on a valid/ready output. It sits between an operand streamer (activations × weights already multiplied) and the output writeback of the NN datapath.

## Interface
- `IN_WIDTH`, 8: width of one lane, unsigned.
- `NUM`, 4: lanes per beat; passed to the tree.
- `OUT_WIDTH`, 32: accumulator and result width.
- `MAX_LEN`, 256: maximum beats per result.
- `LEN_W`, `$clog2(MAX_LEN+1)`: width of `cfg_len`; derived, not overridden.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  begin a job; sampled only in IDLE.
- `cfg_len`  in  LEN_W  beats in this job; sampled when `start` is accepted.
- `busy`  out  1  high in ACC and OUT.
- `err`  out  1  one-cycle pulse on illegal start.
- `in_valid`  in  1  input beat valid.
- `in_ready`  out  1  controller accepts a beat.
- `in_data`  in  NUM*IN_WIDTH  lane i at `[i*IN_WIDTH +: IN_WIDTH]`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  result consumer ready.
- `out_data`  out  OUT_WIDTH  accumulated result.

## Operation
- FSM states: IDLE, ACC, OUT.
- **IDLE**
  - `start` with 1 ≤ `cfg_len` ≤ MAX_LEN: latch `cfg_len` into the remaining-beats counter, clear the accumulator, go to ACC.
  - `start` with `cfg_len` == 0 or > MAX_LEN: stay in IDLE and pulse `err` for one cycle.
- **ACC**
  - `in_ready` = 1.
  - Each beat accepted (`in_valid && in_ready`): acc ← acc + tree_sum, counter ← counter − 1.
  - The accepted beat that takes the counter from 1 to 0 moves the FSM to OUT.
  - A cycle with no beat accepted holds all state.
- **OUT**
  - `out_valid` = 1 and `out_data` = acc, both held stable until `out_ready`.
  - On `out_valid && out_ready`: go to IDLE.
- `start` outside IDLE is ignored; no `err` pulse.
- Arithmetic:
  - Lanes are zero-extended.
  - Tree output is OUT_WIDTH wide.
  - Accumulation wraps modulo 2^OUT_WIDTH; no saturation, no overflow flag.
- `in_ready` is 0 in IDLE and OUT; `out_valid` is 0 in IDLE and ACC.

## Timing
- Reset values: state IDLE; `busy`=0, `err`=0, `in_ready`=0, `out_valid`=0, `out_data`=0; counter and acc = 0.
- `rst_n` low in any state (including mid-ACC or with OUT stalled) returns to IDLE on the next edge. Any partial result is discarded and never presented.
- `start` accepted at cycle t: `busy` and `in_ready` are high from t+1.
- Last beat accepted at cycle t_l: `out_valid` is high from t_l+1; `in_ready` is low from t_l+1.
- Minimum job (`cfg_len`=1, `in_valid` held high, `out_ready` held high): start at cycle 0, beat at 1, result at 2, IDLE at 3.
  - Latency from start to result: 2 cycles.
  - Back-to-back job period: 3 + `cfg_len` − 1 cycles.
- Output handshake: `out_data` must not change while `out_valid` is high and `out_ready` is low.
- Input handshake: `in_ready` does not depend combinationally on `in_valid`. `out_valid` does not depend combinationally on `out_ready`.
- `err` is asserted the cycle after the rejected `start`, for exactly one cycle.

## Structure
- Shared package `nn_ctrl_pkg`: typedef `acc_state_e` {IDLE, ACC, OUT}.
- One sub-module: instance `u_tree` of `adder_tree`.
  - Tree parameters: IN_WIDTH, NUM, OUT_WIDTH.
  - Tree input: `in_data`; tree output: `tree_sum`.
- The tree is purely combinational. The only registers are the FSM, counter, accumulator and `err`.

## Test plan
All cases use default parameters unless stated.
- `cfg_len`=1, beat {1,2,3,4} → `out_data`=10 two cycles after `start`, then IDLE.
- `cfg_len`=3, beats {1,1,1,1}, {2,2,2,2}, {3,3,3,3} with `in_valid` deasserted for 2 cycles between beats → `out_data`=24; no beat is dropped during the bubbles.
- Result 24 with `out_ready` held low for 5 cycles → `out_valid` and `out_data`=24 stable for those 5 cycles. A `start` issued during the stall is ignored.
- Override OUT_WIDTH=10, `cfg_len`=2, all lanes 255 → `out_data`=2040 mod 1024 = 1016.
- `start` with `cfg_len`=0, and separately with `cfg_len`=257 → `err` pulses once each; `busy` stays 0.
- Reset asserted after 2 of 4 beats → next cycle IDLE with all outputs at reset values. A fresh `cfg_len`=1 job with beat {5,5,5,5} then returns 20, with no residue from the aborted job.
